// File: rtl/controlador_2de5.sv
// Serial 2-of-5 word checker/decoder feeding a shift-left BCD digit buffer.
// Each accepted word takes three cycles: accept, count ones, then resolve into the buffer.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | waiting for valid; ready high unless full or clear
// CHECK   | latched word held; ones count being registered
// RESOLVE | ones count known; next edge commits digit or sets erro
module controlador_2de5 #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        code,
    input  logic              valid,
    output logic              ready,
    input  logic              clear,
    output logic [4*NDIG-1:0] digits,
    output logic [2:0]        count,
    output logic              erro,
    output logic              done,
    output logic              full
);

    localparam logic [2:0] NDIG_C = 3'(NDIG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [4:0]        code_q;
    logic [2:0]        ones_q;
    logic              accept;
    logic              word_ok;
    logic [4*NDIG-1:0] ins;

    // Weights 7,4,2,1,0 on code[4..0]; the 7+4 pair encodes digit 0.
    function automatic logic [3:0] decode(input logic [4:0] c);
        logic [3:0] sum;
        sum = (c[4] ? 4'd7 : 4'd0) + (c[3] ? 4'd4 : 4'd0)
            + (c[2] ? 4'd2 : 4'd0) + (c[1] ? 4'd1 : 4'd0);
        return (sum == 4'd11) ? 4'd0 : sum;
    endfunction

    assign full    = (count == NDIG_C);
    assign ready   = rst_n & (state == IDLE) & ~full & ~clear;
    assign accept  = valid & ready;
    assign word_ok = (ones_q == 3'd2);

    always_comb begin
        ins      = '0;
        ins[3:0] = decode(code_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CHECK;
            CHECK:   state_nx = RESOLVE;
            RESOLVE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            ones_q <= '0;
            digits <= '0;
            count  <= '0;
            erro   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                digits <= '0;
                count  <= '0;
                erro   <= 1'b0;
            end else begin
                if (accept) begin
                    code_q <= code;
                end
                if (state == CHECK) begin
                    ones_q <= 3'($countones(code_q));
                end
                if (state == RESOLVE) begin
                    done <= 1'b1;
                    if (word_ok) begin
                        digits <= (digits << 4) | ins;
                        // acceptance is blocked while full, so this guard only backs up the no-wrap rule
                        if (count != NDIG_C) begin
                            count <= count + 3'd1;
                        end
                        erro <= 1'b0;
                    end else begin
                        erro <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_controlador_2de5.sv
// Directed bench for controlador_2de5 (NDIG=4): a scoreboard queue gets the
// predicted buffer state at each acceptance and is checked on each done pulse.
module tb_controlador_2de5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  code;
    logic        valid;
    logic        ready;
    logic        clear;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        erro;
    logic        done;
    logic        full;

    controlador_2de5 #(.NDIG(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .code   (code),
        .valid  (valid),
        .ready  (ready),
        .clear  (clear),
        .digits (digits),
        .count  (count),
        .erro   (erro),
        .done   (done),
        .full   (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic [2:0]  count;
        logic        erro;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_cyc_q[$];
    int          acc_log[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;
    logic [15:0] m_digits = '0;
    int          m_count = 0;
    logic        m_erro = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] ref_dec(input logic [4:0] c);
        case (c)
            5'b11000: return 4'd0;
            5'b00011: return 4'd1;
            5'b00101: return 4'd2;
            5'b00110: return 4'd3;
            5'b01001: return 4'd4;
            5'b01010: return 4'd5;
            5'b01100: return 4'd6;
            5'b10001: return 4'd7;
            5'b10010: return 4'd8;
            5'b10100: return 4'd9;
            default:  return 4'hF;
        endcase
    endfunction

    function automatic void predict(input logic [4:0] c);
        int   ones;
        exp_t e;
        ones = 0;
        for (int i = 0; i < 5; i++) ones += int'(c[i]);
        if (ones == 2) begin
            m_digits = {m_digits[11:0], ref_dec(c)};
            m_count++;
            m_erro = 1'b0;
        end else begin
            m_erro = 1'b1;
        end
        e.digits = m_digits;
        e.count  = 3'(m_count);
        e.erro   = m_erro;
        e.full   = (m_count == 4);
        exp_q.push_back(e);
    endfunction

    function automatic void model_flush();
        m_digits = '0;
        m_count  = 0;
        m_erro   = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && valid && ready) begin
            predict(code);
            acc_cyc_q.push_back(cyc);
            acc_log.push_back(cyc);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_digits", 32'(digits), 32'(e.digits));
                check("sb_count", 32'(count), 32'(e.count));
                check("sb_erro", 32'(erro), 32'(e.erro));
                check("sb_full", 32'(full), 32'(e.full));
                check("sb_latency", 32'(cyc - acc_cyc_q.pop_front()), 32'd2);
            end
        end
        prev_done = done;
    end

    task automatic send(input logic [4:0] c);
        int n;
        bit ok;
        @(negedge clk);
        code  = c;
        valid = 1'b1;
        n     = acc_cnt;
        ok    = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (acc_cnt != n) ok = 1'b1;
        end
        check("send_accepted", 32'(ok), 32'd1);
        valid = 1'b0;
        code  = 5'($urandom_range(0, 31));
    endtask

    task automatic drain();
        bit ok;
        ok = (exp_q.size() == 0);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1'b1;
        end
        check("drain_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        model_flush();
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int          n;
        int          k;
        int          d;
        logic [4:0]  b2b[6];
        rst_n = 1'b0;
        code  = 5'b0;
        valid = 1'b0;
        clear = 1'b0;
        b2b   = '{5'b01010, 5'b11100, 5'b00011, 5'b00000, 5'b10010, 5'b01111};

        #2;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(ready), 32'd1);

        // valid word then three invalid ones
        send(5'b01010);
        drain();
        check("first_digit", 32'(digits[3:0]), 32'd5);
        send(5'b11100);
        send(5'b00000);
        send(5'b00001);
        drain();
        repeat (4) @(negedge clk);
        check("erro_holds", 32'(erro), 32'd1);
        check("invalid_keeps_count", 32'(count), 32'd1);

        // fill the buffer, then hold a word against a full buffer
        do_clear();
        #1;
        check("clear_erro", 32'(erro), 32'd0);
        send(5'b11000);
        send(5'b00011);
        send(5'b00101);
        send(5'b00110);
        drain();
        check("full_digits", 32'(digits), 32'h0123);
        check("full_count", 32'(count), 32'd4);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(ready), 32'd0);
        @(negedge clk);
        code  = 5'b01001;
        valid = 1'b1;
        n     = acc_cnt;
        repeat (8) @(negedge clk);
        check("full_no_accept", 32'(acc_cnt), 32'(n));
        check("full_ready_held", 32'(ready), 32'd0);
        clear = 1'b1;
        model_flush();
        @(negedge clk);
        clear = 1'b0;
        check("after_clear_count", 32'(count), 32'd0);
        @(negedge clk);
        check("held_word_accepted", 32'(acc_cnt), 32'(n + 1));
        valid = 1'b0;
        drain();

        // clear during CHECK aborts the word
        do_clear();
        send(5'b10100);
        clear = 1'b1;
        n     = done_cnt;
        model_flush();
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("abort_count", 32'(count), 32'd0);
        check("abort_idle_ready", 32'(ready), 32'd1);
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(n));

        // clear and valid together
        @(negedge clk);
        valid = 1'b1;
        clear = 1'b1;
        code  = 5'b00110;
        n     = acc_cnt;
        model_flush();
        #1;
        check("clear_valid_ready", 32'(ready), 32'd0);
        @(negedge clk);
        check("clear_valid_no_accept", 32'(acc_cnt), 32'(n));
        valid = 1'b0;
        clear = 1'b0;

        // async reset while in RESOLVE
        send(5'b01001);
        drain();
        send(5'b01100);
        n = done_cnt;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_digits", 32'(digits), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_erro", 32'(erro), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ready", 32'(ready), 32'd0);
        model_flush();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_no_done", 32'(done_cnt), 32'(n));

        // back-to-back with valid held and code changing every cycle
        n     = acc_cnt;
        k     = 0;
        valid = 1'b1;
        for (int i = 0; i < 40 && acc_cnt < n + 4; i++) begin
            code = b2b[k % 6];
            k++;
            @(negedge clk);
        end
        valid = 1'b0;
        check("b2b_accepts", 32'(acc_cnt - n), 32'd4);
        drain();
        if (acc_log.size() >= 4) begin
            for (int i = acc_log.size() - 3; i < acc_log.size(); i++) begin
                d = acc_log[i] - acc_log[i - 1];
                check("b2b_spacing", 32'(d), 32'd3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controlador_2de5.md
CONTROLADOR_2DE5 -- requirements
Module: controlador_2de5

Interface
REQ-001 Parameter NDIG, default 4, meaning: digit buffer depth in digits, legal range 1..7.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 code  input  5  2-of-5 word; code[4..0] SHALL carry weights 7,4,2,1,0.
REQ-005 valid  input  1  producer offers code this cycle.
REQ-006 ready  output  1  block accepts code this cycle.
REQ-007 clear  input  1  synchronous flush of buffer and status.
REQ-008 digits  output  4*NDIG  BCD buffer; digits[3:0] SHALL hold the most recent digit.
REQ-009 count  output  3  number of stored digits, 0..NDIG.
REQ-010 erro  output  1  0 = last checked word valid; 1 = invalid.
REQ-011 done  output  1  one-cycle pulse when a word finishes checking.
REQ-012 full  output  1  high when count == NDIG.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CHECK and RESOLVE.
REQ-014 ready SHALL equal rst_n AND (state == IDLE) AND NOT full AND NOT clear, combinationally.
REQ-015 Acceptance SHALL occur at a rising edge where valid and ready are both 1; the edge SHALL latch code into an internal register and move IDLE to CHECK.
REQ-016 Changes on code or valid after acceptance SHALL have no effect on the word in progress.
REQ-017 In CHECK (one cycle), the block SHALL count the ones in the latched word (0..5), register the result, and move to RESOLVE.
REQ-018 In RESOLVE (one cycle), if ones == 2, the next edge SHALL shift digits left by 4 bits, insert the decoded BCD value at digits[3:0], increment count, clear erro, pulse done, and return to IDLE.
REQ-019 In RESOLVE, if ones != 2, the next edge SHALL leave digits and count unchanged, set erro, pulse done, and return to IDLE.
REQ-020 Decode SHALL be the weighted sum, except that a sum of 11 SHALL map to 0: 11000->0, 00011->1, 00101->2, 00110->3, 01001->4, 01010->5, 01100->6, 10001->7, 10010->8, 10100->9.
REQ-021 Latency SHALL be fixed: done, erro, digits and count SHALL update at the second rising edge after the acceptance edge.
REQ-022 Maximum throughput SHALL be one word per 3 cycles, because ready is low in CHECK and RESOLVE.
REQ-023 done SHALL be high for exactly one cycle per completed word and low otherwise.
REQ-024 erro SHALL hold its value until the next completion, clear, or reset.
REQ-025 Full: while count == NDIG, ready SHALL be 0 and valid SHALL be ignored; the producer holds its word, and no word is lost or overwritten.
REQ-026 Full: a valid word completing into the last free slot SHALL set full at the same edge it updates count.
REQ-027 An all-zero, single-one, or three-or-more-ones word SHALL be an error.
REQ-028 clear sampled high at a rising edge, in any state, SHALL set digits = 0, count = 0 and erro = 0, and return the FSM to IDLE.
REQ-029 clear in CHECK or RESOLVE SHALL abort the word in progress, with no done pulse.
REQ-030 When clear and valid are high together, clear SHALL win: ready is 0 that cycle and no acceptance occurs.
REQ-031 count SHALL never exceed NDIG and SHALL never wrap.

Reset
REQ-032 While rst_n is low, regardless of clk: state = IDLE, digits = 0, count = 0, erro = 0, done = 0, full = 0, ready = 0, and the latched code = 0.
REQ-033 Reset asserted mid-word SHALL discard the word with no done pulse.
REQ-034 After rst_n rises, ready SHALL be 1 in the first cycle, provided clear is low.

Verification
REQ-035 Valid word: after reset, offer code=01010 with valid for one cycle -> accepted; done at 2nd edge after acceptance; digits[3:0]=5, count=1, erro=0.
REQ-036 Invalid words: offer 11100, then 00000, then 00001 -> each gives done with erro=1; digits and count unchanged.
REQ-037 Full buffer (NDIG=4): 11000, 00011, 00101, 00110 -> digits=16'h0123, count=4, full=1, ready=0; a fifth held valid word is not accepted until clear; after clear, count=0 and the word is accepted.
REQ-038 Clear abort: assert clear in the CHECK cycle of word 10100 -> no done pulse, count=0, FSM in IDLE; clear together with valid -> no acceptance.
REQ-039 Async reset in RESOLVE -> all outputs 0 immediately, with no clk edge required; no done pulse after release.
REQ-040 Back-to-back: valid held high with changing codes -> acceptances exactly 3 cycles apart; each result matches the word latched at its own acceptance edge.
